// File: rtl/multicycle_control.sv
// Main sequencing FSM for the multicycle RV32I core.
// Steps each instruction through fetch/decode/execute/memory/writeback.
// It also drives every datapath enable and mux select.
//
// state    | meaning
// ---------+-----------------------------------------------------
// RESET    | idle after reset, all outputs low
// FETCH    | load IR/oldPC, PC <= PC + 4
// DECODE   | present immSrc, dispatch on opcode
// MEMADR   | ALUOut <= rs1 + imm (lw/sw/jalr)
// MEMREAD  | read data memory at ALUOut
// MEMWB    | rd <= memData
// MEMWRITE | store rs2 at ALUOut
// EXECR    | ALUOut <= rs1 op rs2
// EXECI    | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// TARGET   | ALUOut <= oldPC + imm (branch/jal/auipc)
// BRANCH   | compare rs1/rs2, PC <= ALUOut when taken
// JAL      | PC <= ALUOut target, ALUOut <= oldPC + 4
// LUI      | rd <= immExt
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [2:0] immSrc,
  output logic       illegal,
  output logic       instrDone,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_TARGET   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JAL      = 4'd12,
    S_LUI      = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t state_q, state_d;
  logic [2:0] imm_sel;
  logic       br_taken;
  logic       br_bad;

  assign state = state_q;

  // State register; reset is asynchronous so outputs drop without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  // Immediate format from the opcode held in IR; stays constant for the whole instruction.
  always_comb begin
    imm_sel = 3'b111;
    unique case (opcode)
      OP_LOAD, OP_JALR:   imm_sel = 3'b000;
      OP_IMM:             imm_sel = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'b101 : 3'b000;
      OP_STORE:           imm_sel = 3'b001;
      OP_BRANCH:          imm_sel = 3'b010;
      OP_JAL:             imm_sel = 3'b011;
      OP_LUI, OP_AUIPC:   imm_sel = 3'b100;
      default:            imm_sel = 3'b111;
    endcase
  end

  // Branch condition from the ALU flags; funct3 010/011 have no branch meaning.
  always_comb begin
    br_taken = 1'b0;
    br_bad   = 1'b0;
    unique case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = ~zero;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = ~lt;
      3'b110:  br_taken = ltu;
      3'b111:  br_taken = ~ltu;
      default: br_bad   = 1'b1;
    endcase
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d   = S_RESET;
    pcWrite   = 1'b0;
    adrSrc    = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    regWrite  = 1'b0;
    resultSrc = 2'b00;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    illegal   = 1'b0;
    instrDone = 1'b0;
    immSrc    = (state_q == S_RESET || state_q == S_FETCH) ? 3'b000 : imm_sel;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        irWrite   = 1'b1;
        pcWrite   = 1'b1;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE, OP_JALR:   state_d = S_MEMADR;
          OP_REG:                       state_d = S_EXECR;
          OP_IMM:                       state_d = S_EXECI;
          OP_BRANCH, OP_JAL, OP_AUIPC:  state_d = S_TARGET;
          OP_LUI:                       state_d = S_LUI;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        case (opcode)
          OP_LOAD:  state_d = S_MEMREAD;
          OP_STORE: state_d = S_MEMWRITE;
          OP_JALR:  state_d = S_JAL;
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEMREAD: begin
        adrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        adrSrc    = 1'b1;
        memWrite  = 1'b1;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECR: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        aluOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_TARGET: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (opcode)
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_AUIPC:  state_d = S_ALUWB;
          default:   state_d = S_FETCH;
        endcase
      end
      S_BRANCH: begin
        aluSrcA   = 2'b10;
        aluOp     = 2'b01;
        instrDone = 1'b1;
        pcWrite   = br_taken;
        illegal   = br_bad;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        pcWrite = 1'b1;
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        resultSrc = 2'b11;
        regWrite  = 1'b1;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// from FETCH and checks the state sequence and key controls per cycle.
module tb_multicycle_control;
  logic       clk, reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero, lt, ltu;
  logic       pcWrite, adrSrc, memWrite, irWrite, regWrite;
  logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp;
  logic [2:0] immSrc;
  logic       illegal, instrDone;
  logic [3:0] state;
  int n_tests = 0;
  int n_fail  = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .zero(zero), .lt(lt), .ltu(ltu),
    .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite),
    .irWrite(irWrite), .regWrite(regWrite), .resultSrc(resultSrc),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .immSrc(immSrc), .illegal(illegal), .instrDone(instrDone),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_tests++;
    if (state !== 4'd0 || pcWrite !== 1'b0 || irWrite !== 1'b0 || regWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d pcWrite=%b irWrite=%b regWrite=%b want 0", state, pcWrite, irWrite, regWrite);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    n_tests++;
    if (state !== 4'd1 || irWrite !== 1'b1 || pcWrite !== 1'b1 || aluSrcB !== 2'b10 || resultSrc !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_first_fetch: state=%0d irWrite=%b pcWrite=%b aluSrcB=%b resultSrc=%b want 1/1/1/10/10",
               state, irWrite, pcWrite, aluSrcB, resultSrc);
    end
  endtask

  task automatic test_lw();
    logic [3:0] exp [0:4];
    exp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    opcode = 7'b0000011; funct3 = 3'b010;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (state !== exp[i] || regWrite !== (i == 4) || instrDone !== (i == 4) ||
          (i >= 1 && immSrc !== 3'b000) || (i == 4 && resultSrc !== 2'b01) || (i == 3 && adrSrc !== 1'b1)) begin
        n_fail++;
        $display("FAIL lw[%0d]: state=%0d regWrite=%b instrDone=%b immSrc=%b resultSrc=%b adrSrc=%b want state %0d",
                 i, state, regWrite, instrDone, immSrc, resultSrc, adrSrc, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_sw();
    logic [3:0] exp [0:3];
    exp = '{4'd1, 4'd2, 4'd3, 4'd6};
    opcode = 7'b0100011; funct3 = 3'b010;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (state !== exp[i] || memWrite !== (i == 3) || regWrite !== 1'b0 || instrDone !== (i == 3) ||
          (i >= 1 && immSrc !== 3'b001) || (i == 2 && aluSrcB !== 2'b01)) begin
        n_fail++;
        $display("FAIL sw[%0d]: state=%0d memWrite=%b regWrite=%b immSrc=%b aluSrcB=%b want state %0d",
                 i, state, memWrite, regWrite, immSrc, aluSrcB, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_branch(input logic [2:0] f3, input logic z, input logic l, input logic lu,
                             input logic exp_taken, input logic exp_illegal);
    logic [3:0] exp [0:3];
    exp = '{4'd1, 4'd2, 4'd10, 4'd11};
    opcode = 7'b1100011; funct3 = f3; zero = z; lt = l; ltu = lu;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (state !== exp[i] || (i >= 1 && immSrc !== 3'b010) ||
          (i == 3 && (pcWrite !== exp_taken || illegal !== exp_illegal || instrDone !== 1'b1 || aluOp !== 2'b01)) ||
          (i == 2 && pcWrite !== 1'b0)) begin
        n_fail++;
        $display("FAIL branch_f3_%b[%0d]: state=%0d pcWrite=%b illegal=%b immSrc=%b aluOp=%b want state %0d taken %b ill %b",
                 f3, i, state, pcWrite, illegal, immSrc, aluOp, exp[i], exp_taken, exp_illegal);
      end
      step();
    end
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;
  endtask

  task automatic test_alu_imm(input logic [2:0] f3, input logic [2:0] exp_imm);
    logic [3:0] exp [0:3];
    exp = '{4'd1, 4'd2, 4'd8, 4'd9};
    opcode = 7'b0010011; funct3 = f3;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (state !== exp[i] || regWrite !== (i == 3) || instrDone !== (i == 3) ||
          (i >= 1 && immSrc !== exp_imm) || (i == 2 && (aluSrcB !== 2'b01 || aluOp !== 2'b10))) begin
        n_fail++;
        $display("FAIL itype_f3_%b[%0d]: state=%0d regWrite=%b immSrc=%b aluSrcB=%b want state %0d imm %b",
                 f3, i, state, regWrite, immSrc, aluSrcB, exp[i], exp_imm);
      end
      step();
    end
  endtask

  task automatic test_rtype();
    logic [3:0] exp [0:3];
    exp = '{4'd1, 4'd2, 4'd7, 4'd9};
    opcode = 7'b0110011; funct3 = 3'b000;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (state !== exp[i] || regWrite !== (i == 3) || (i >= 1 && immSrc !== 3'b111) ||
          (i == 2 && (aluSrcA !== 2'b10 || aluSrcB !== 2'b00 || aluOp !== 2'b10))) begin
        n_fail++;
        $display("FAIL rtype[%0d]: state=%0d regWrite=%b immSrc=%b aluSrcA=%b aluOp=%b want state %0d",
                 i, state, regWrite, immSrc, aluSrcA, aluOp, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_jal();
    logic [3:0] exp [0:4];
    exp = '{4'd1, 4'd2, 4'd10, 4'd12, 4'd9};
    opcode = 7'b1101111; funct3 = 3'b000;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (state !== exp[i] || pcWrite !== (i == 0 || i == 3) || regWrite !== (i == 4) ||
          (i >= 1 && immSrc !== 3'b011) || (i == 3 && (resultSrc !== 2'b00 || aluSrcA !== 2'b01 || aluSrcB !== 2'b10))) begin
        n_fail++;
        $display("FAIL jal[%0d]: state=%0d pcWrite=%b regWrite=%b immSrc=%b resultSrc=%b want state %0d",
                 i, state, pcWrite, regWrite, immSrc, resultSrc, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_jalr();
    logic [3:0] exp [0:4];
    exp = '{4'd1, 4'd2, 4'd3, 4'd12, 4'd9};
    opcode = 7'b1100111; funct3 = 3'b000;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (state !== exp[i] || pcWrite !== (i == 0 || i == 3) || regWrite !== (i == 4) ||
          instrDone !== (i == 4) || (i >= 1 && immSrc !== 3'b000)) begin
        n_fail++;
        $display("FAIL jalr[%0d]: state=%0d pcWrite=%b regWrite=%b immSrc=%b want state %0d",
                 i, state, pcWrite, regWrite, immSrc, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_auipc();
    logic [3:0] exp [0:3];
    exp = '{4'd1, 4'd2, 4'd10, 4'd9};
    opcode = 7'b0010111; funct3 = 3'b000;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (state !== exp[i] || regWrite !== (i == 3) || (i >= 1 && immSrc !== 3'b100)) begin
        n_fail++;
        $display("FAIL auipc[%0d]: state=%0d regWrite=%b immSrc=%b want state %0d", i, state, regWrite, immSrc, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_lui();
    logic [3:0] exp [0:2];
    exp = '{4'd1, 4'd2, 4'd13};
    opcode = 7'b0110111; funct3 = 3'b000;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (state !== exp[i] || regWrite !== (i == 2) || instrDone !== (i == 2) ||
          (i >= 1 && immSrc !== 3'b100) || (i == 2 && resultSrc !== 2'b11)) begin
        n_fail++;
        $display("FAIL lui[%0d]: state=%0d regWrite=%b resultSrc=%b immSrc=%b want state %0d",
                 i, state, regWrite, resultSrc, immSrc, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_illegal();
    logic [3:0] exp [0:2];
    exp = '{4'd1, 4'd2, 4'd1};
    opcode = 7'b1111111; funct3 = 3'b000;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (state !== exp[i] || illegal !== (i == 1) || regWrite !== 1'b0 || memWrite !== 1'b0 ||
          instrDone !== 1'b0 || (i == 1 && immSrc !== 3'b111)) begin
        n_fail++;
        $display("FAIL illegal_op[%0d]: state=%0d illegal=%b regWrite=%b memWrite=%b instrDone=%b want state %0d",
                 i, state, illegal, regWrite, memWrite, instrDone, exp[i]);
      end
      step();
    end
    // the machine re-entered FETCH at i==2 and has now advanced; realign to FETCH
    opcode = 7'b0110111;
    step();
    step();
  endtask

  task automatic test_reset_midflight();
    opcode = 7'b0000011; funct3 = 3'b010;
    step(); step(); step();
    n_tests++;
    if (state !== 4'd4) begin
      n_fail++;
      $display("FAIL midflight_reach_memread: state=%0d want 4", state);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (state !== 4'd0 || regWrite !== 1'b0 || memWrite !== 1'b0 || pcWrite !== 1'b0 || adrSrc !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_async_reset: state=%0d regWrite=%b memWrite=%b pcWrite=%b adrSrc=%b want 0",
               state, regWrite, memWrite, pcWrite, adrSrc);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    n_tests++;
    if (state !== 4'd1 || irWrite !== 1'b1 || pcWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL midflight_refetch: state=%0d irWrite=%b pcWrite=%b want 1/1/1", state, irWrite, pcWrite);
    end
  endtask

  initial begin
    reset = 1'b0; opcode = 7'b0; funct3 = 3'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    #2 reset = 1'b1;
    #1;
    test_reset();
    test_lw();
    test_sw();
    test_branch(3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    test_branch(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_branch(3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    test_branch(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    test_branch(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    test_branch(3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    test_branch(3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    test_branch(3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    test_alu_imm(3'b001, 3'b101);
    test_alu_imm(3'b000, 3'b000);
    test_alu_imm(3'b101, 3'b101);
    test_rtype();
    test_jal();
    test_jalr();
    test_auipc();
    test_lui();
    test_illegal();
    test_lw();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main sequencing FSM for the multicycle RV32I core. Steps each instruction through fetch, decode, execute, memory and writeback states, and drives all datapath enables and mux selects. Drives `immSrc` to the immediate extender, which registers its output, so `immExt` is valid one cycle after `immSrc` is presented. Sits beside the datapath and takes `opcode`/`funct3` from the instruction register and flags from the ALU.

## Interface
- No parameters.
- `clk` in 1: core clock, all state changes on rising edge.
- `reset` in 1: asynchronous, active-high; forces state RESET immediately.
- `opcode` in 7: instr[6:0] from the instruction register.
- `funct3` in 3: instr[14:12].
- `zero` in 1: ALU result == 0 (rs1 − rs2).
- `lt` in 1: signed rs1 < rs2.
- `ltu` in 1: unsigned rs1 < rs2.
- `pcWrite` out 1: PC load enable.
- `adrSrc` out 1: memory address select; 0 = PC, 1 = result bus.
- `memWrite` out 1: data memory write enable.
- `irWrite` out 1: load IR and oldPC.
- `regWrite` out 1: register file write enable.
- `resultSrc` out 2: result bus select; 00 = ALUOut, 01 = memData, 10 = ALU direct, 11 = immExt.
- `aluSrcA` out 2: ALU operand A select; 00 = PC, 01 = oldPC, 10 = rs1 register.
- `aluSrcB` out 2: ALU operand B select; 00 = rs2 register, 01 = immExt, 10 = constant 4.
- `aluOp` out 2: ALU operation; 00 = add, 01 = subtract/compare, 10 = decoded from funct fields.
- `immSrc` out 3: extender select; 000 = I/L, 001 = S, 010 = B, 011 = J, 100 = U, 101 = shift-immediate, 111 = none.
- `illegal` out 1: one-cycle pulse on an unsupported opcode or branch funct3.
- `instrDone` out 1: high in the final cycle of each instruction.
- `state` out 4: current state, for debug.

## Operation
- State encoding: RESET 0, FETCH 1, DECODE 2, MEMADR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXECR 7, EXECI 8, ALUWB 9, TARGET 10, BRANCH 11, JAL 12, LUI 13. States 14 and 15 go to RESET.
- Outputs are a Moore decode of `state`. Exceptions: `immSrc` and `illegal` also depend on `opcode`/`funct3`; branch `pcWrite` also depends on the flags. Any output not listed for a state is 0.
- RESET: all outputs 0; `immSrc` = 000. Next state FETCH.
- FETCH: `irWrite`=1, `pcWrite`=1, `aluSrcA`=00, `aluSrcB`=10, `aluOp`=00, `resultSrc`=10, `immSrc`=000. Next state DECODE.
- DECODE: no enables asserted. Next state by opcode:
  - 0000011 lw or 0100011 sw or 1100111 jalr → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011, 1101111, 0010111 → TARGET
  - 0110111 → LUI
  - any other opcode → FETCH with `illegal`=1
- MEMADR: `aluSrcA`=10, `aluSrcB`=01, `aluOp`=00. Next: lw → MEMREAD, sw → MEMWRITE, jalr → JAL.
- MEMREAD: `adrSrc`=1, `resultSrc`=00. Next MEMWB.
- MEMWB: `resultSrc`=01, `regWrite`=1, `instrDone`=1. Next FETCH.
- MEMWRITE: `adrSrc`=1, `resultSrc`=00, `memWrite`=1, `instrDone`=1. Next FETCH.
- EXECR: `aluSrcA`=10, `aluSrcB`=00, `aluOp`=10. Next ALUWB.
- EXECI: `aluSrcA`=10, `aluSrcB`=01, `aluOp`=10. Next ALUWB.
- ALUWB: `resultSrc`=00, `regWrite`=1, `instrDone`=1. Next FETCH.
- TARGET: `aluSrcA`=01, `aluSrcB`=01, `aluOp`=00; ALUOut receives oldPC+imm. Next: branch → BRANCH, jal → JAL, auipc → ALUWB.
- BRANCH: `aluSrcA`=10, `aluSrcB`=00, `aluOp`=01, `resultSrc`=00, `instrDone`=1. Next FETCH.
  - `pcWrite` = taken: funct3 000 → `zero`, 001 → !`zero`, 100 → `lt`, 101 → !`lt`, 110 → `ltu`, 111 → !`ltu`.
  - funct3 010/011: not taken, `illegal`=1.
- JAL: `pcWrite`=1, `resultSrc`=00 (PC ← ALUOut target), `aluSrcA`=01, `aluSrcB`=10, `aluOp`=00 (ALUOut ← oldPC+4). Next ALUWB.
- LUI: `resultSrc`=11, `regWrite`=1, `instrDone`=1. Next FETCH.
- `immSrc` outside RESET/FETCH, from `opcode` held in IR:
  - lw, jalr → 000
  - I-ALU → 101 if funct3 is 001/101, else 000
  - S → 001; B → 010; J → 011; LUI/AUIPC → 100; R and unknown → 111
- `immSrc` is held constant from DECODE to the end of the instruction, because the extender re-latches every cycle.
- jalr bit-0 clearing is handled by the datapath, not this block.

## Timing
- `immSrc` becomes valid in DECODE; `immExt` is valid from the next state onward. Any state using `aluSrcB`=01 or `resultSrc`=11 is therefore at least one cycle after DECODE.
- Cycles per instruction, FETCH through `instrDone`: lw 5, sw 4, R 4, I 4, branch 4, jal 5, jalr 5, lui 3, auipc 4. Illegal opcode: 2 cycles, no `instrDone`.
- `reset` asserted in any state: state goes to 0 and all outputs go to 0 within the same cycle, with no clock needed. First FETCH is one clock edge after `reset` deasserts.
- Branch flags are sampled combinationally in BRANCH only.

## Test plan
- Reset: assert `reset` mid-MEMREAD → `state`=0 and `regWrite`/`memWrite`/`pcWrite` all 0 immediately. Deassert → FETCH after 1 edge with `irWrite`=1, `pcWrite`=1.
- lw (opcode 0000011): states 1,2,3,4,5. `immSrc`=000 from DECODE on; `regWrite` only in MEMWB with `resultSrc`=01; `instrDone` at cycle 5.
- beq, funct3 000: `zero`=1 → `pcWrite`=1 in BRANCH, `immSrc`=010. Repeat with `zero`=0 → `pcWrite`=0. bltu with `ltu`=1 → taken.
- slli (0010011, funct3 001) → `immSrc`=101. addi (funct3 000) → `immSrc`=000. Both 4 cycles, `regWrite` in ALUWB.
- jal: states 1,2,10,12,9. `pcWrite` in JAL with `resultSrc`=00, then `regWrite` in ALUWB, `immSrc`=011. jalr: states 1,2,3,12,9 with `immSrc`=000.
- Opcode 1111111 → `illegal`=1 in DECODE, returns to FETCH, no `regWrite`/`memWrite`. lui: 3 cycles with `resultSrc`=11, `immSrc`=100.
